// File: rtl/ldtu_ser_bank_nch.sv
`default_nettype none
// ---------------------------------------------------------------------------------------
// ldtu_ser_bank_nch: NCH-lane MSB-first serializer bank with a shared word handshake,
// idle-word fill and saturating per-lane underrun counters. Optional SER_PRBS_EN adds a PRBS7 mode. Rev 1.0
// ---------------------------------------------------------------------------------------
module ldtu_ser_bank_nch #(
  parameter int          NCH       = 4,
  parameter int          WORD_W    = 32,
  parameter int          CNT_W     = 8,
  parameter logic [31:0] IDLE_WORD = 32'hEAAAAAAA
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [NCH*WORD_W-1:0] data_in,
  input  logic [NCH-1:0]        data_valid,
  input  logic                  cnt_clear,
`ifdef SER_PRBS_EN
  input  logic                  prbs_mode,
`endif
  output logic                  handshake,
  output logic                  word_start,
  output logic [NCH-1:0]        ser_out,
  output logic [NCH*CNT_W-1:0]  underrun_cnt
);

  localparam int              CW      = $clog2(WORD_W);
  localparam logic [CW-1:0]   LAST    = CW'(WORD_W - 1);
  localparam logic [CW-1:0]   PRELAST = CW'(WORD_W - 2);
  localparam logic [WORD_W-1:0] IDLE_W = WORD_W'(IDLE_WORD);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] bit_cnt;
  logic          hs_pend;
  logic          load;
  logic          prbs_on;
  logic          prbs_bit;
  logic          prbs_load;

  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      hs_pend    <= 1'b0;
      word_start <= 1'b0;
    end else begin
      state      <= state_nx;
      hs_pend    <= handshake;
      word_start <= load;
      if (state == S_IDLE) begin
        if (enable) bit_cnt <= PRELAST;
      end else if (bit_cnt == LAST) begin
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // A word only ends at the wrap edge, so stopping never truncates one.
  always_comb begin
    state_nx  = state;
    handshake = 1'b0;
    load      = 1'b0;
    case (state)
      S_IDLE: if (enable) state_nx = S_RUN;
      S_RUN: begin
        handshake = (bit_cnt == PRELAST) && enable;
        if (bit_cnt == LAST) begin
          load = hs_pend;
          if (!hs_pend) state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

`ifdef SER_PRBS_EN
  logic [6:0] prbs_lfsr;

  assign prbs_load = prbs_mode;
  assign prbs_bit  = prbs_lfsr[6] ^ prbs_lfsr[5];

  always_ff @(posedge clock) begin
    if (rst) begin
      prbs_on   <= 1'b0;
      prbs_lfsr <= 7'h7F;
    end else begin
      if (load)                    prbs_on <= prbs_mode;
      else if (state_nx == S_IDLE) prbs_on <= 1'b0;
      // Held at the seed while inactive, so every PRBS run starts from 7'h7F.
      if (!prbs_on || (load && !prbs_mode)) prbs_lfsr <= 7'h7F;
      else if (state == S_RUN)              prbs_lfsr <= {prbs_lfsr[5:0], prbs_bit};
    end
  end
`else
  assign prbs_load = 1'b0;
  assign prbs_bit  = 1'b0;
  assign prbs_on   = 1'b0;
`endif

  for (genvar ch = 0; ch < NCH; ch++) begin : g_lane
    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              underrun;

    assign underrun = load && !data_valid[ch] && !prbs_load;

    always_ff @(posedge clock) begin
      if (rst) begin
        shreg <= '0;
      end else if (load) begin
        shreg <= data_valid[ch] ? data_in[ch*WORD_W +: WORD_W] : IDLE_W;
      end else if (state == S_RUN) begin
        shreg <= {shreg[WORD_W-2:0], 1'b0};
      end
    end

    always_ff @(posedge clock) begin
      if (rst || cnt_clear) begin
        cnt <= '0;
      end else if (underrun && (cnt != {CNT_W{1'b1}})) begin
        cnt <= cnt + 1'b1;
      end
    end

    assign ser_out[ch]                      = prbs_on ? prbs_bit : shreg[WORD_W-1];
    assign underrun_cnt[ch*CNT_W +: CNT_W]  = cnt;
  end

endmodule
`default_nettype wire
